// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier sequencer: one-hot state
// encoding, bit positions for direct state decode, and default sizing.
package mult_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  localparam int I_IDLE  = 0;
  localparam int I_INIT  = 1;
  localparam int I_ADD   = 2;
  localparam int I_SHIFT = 3;
  localparam int I_DONE  = 4;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_INIT  = 5'b00010,
    S_ADD   = 5'b00100,
    S_SHIFT = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

endpackage

// File: rtl/mult_ctrl_cnt.sv
// Iteration counter for the multiplier sequencer: synchronous clear,
// increment, and a terminal flag on the last bit position.
module mult_ctrl_cnt
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + CNT_W'(1);
  end

  assign term = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for the shift-add multiplier datapath. Control outputs decode
// straight from one-hot state flops so the async product clear never glitches.
//
//   state | meaning
//   IDLE  | wait for start
//   INIT  | load operands, clear product, reset count/carry
//   ADD   | load adder sum into product high half, latch carry-out
//   SHIFT | shift product/multiplier right, carry into product MSB
//   DONE  | one-cycle done pulse, product valid
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic Mult_Ctrl_Clock,
  input  logic Mult_Ctrl_Clear,
  input  logic Mult_Ctrl_Start,
  input  logic Mult_Ctrl_Q0,
  input  logic Mult_Ctrl_Adder_Cout,
  output logic Mult_Ctrl_Load_Ops,
  output logic Mult_Ctrl_Clear_P,
  output logic Mult_Ctrl_Load_P,
  output logic Mult_Ctrl_Shift,
  output logic Mult_Ctrl_Carry,
  output logic Mult_Ctrl_Busy,
  output logic Mult_Ctrl_Done
);

  state_t           state, state_nxt;
  logic             carry_q, carry_nxt;
  logic             busy_q, busy_nxt;
  logic             cnt_clr, cnt_inc;
  logic [CNT_W-1:0] count;
  logic             term;

  mult_ctrl_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (Mult_Ctrl_Clock),
    .rst   (Mult_Ctrl_Clear),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (count),
    .term  (term)
  );

  always_ff @(posedge Mult_Ctrl_Clock or posedge Mult_Ctrl_Clear) begin
    if (Mult_Ctrl_Clear) begin
      state   <= S_IDLE;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      carry_q <= carry_nxt;
      busy_q  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    carry_nxt = carry_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (Mult_Ctrl_Start) state_nxt = S_INIT;
      end
      S_INIT: begin
        cnt_clr   = 1'b1;
        carry_nxt = 1'b0;
        state_nxt = Mult_Ctrl_Q0 ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        carry_nxt = Mult_Ctrl_Adder_Cout;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        carry_nxt = 1'b0;
        cnt_inc   = 1'b1;
        if (term)              state_nxt = S_DONE;
        else if (Mult_Ctrl_Q0) state_nxt = S_ADD;
        else                   state_nxt = S_SHIFT;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        carry_nxt = 1'b0;
      end
    endcase
    // Busy gets its own flop so it is not an OR of state bits
    busy_nxt = state_nxt[I_INIT] | state_nxt[I_ADD] | state_nxt[I_SHIFT];
  end

  assign Mult_Ctrl_Load_Ops = state[I_INIT];
  assign Mult_Ctrl_Clear_P  = state[I_INIT];
  assign Mult_Ctrl_Load_P   = state[I_ADD];
  assign Mult_Ctrl_Shift    = state[I_SHIFT];
  assign Mult_Ctrl_Carry    = state[I_SHIFT] & carry_q;
  assign Mult_Ctrl_Busy     = busy_q;
  assign Mult_Ctrl_Done     = state[I_DONE];

endmodule

// File: tb/tb_mult_ctrl.sv
// Directed bench for mult_ctrl with a small behavioural shift-add datapath
// closing the loop through Q0 and Adder_Cout.
module tb_mult_ctrl;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic q0, adder_cout;
  logic load_ops, clear_p, load_p, shift, carry, busy, done;
  logic [6:0] outs;

  logic [3:0] a_in = 4'd0, b_in = 4'd0;
  logic [3:0] areg, mreg;
  logic [7:0] p;
  logic [4:0] sum;
  logic       force_cout = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_ctrl dut (
    .Mult_Ctrl_Clock      (clk),
    .Mult_Ctrl_Clear      (rst),
    .Mult_Ctrl_Start      (start),
    .Mult_Ctrl_Q0         (q0),
    .Mult_Ctrl_Adder_Cout (adder_cout),
    .Mult_Ctrl_Load_Ops   (load_ops),
    .Mult_Ctrl_Clear_P    (clear_p),
    .Mult_Ctrl_Load_P     (load_p),
    .Mult_Ctrl_Shift      (shift),
    .Mult_Ctrl_Carry      (carry),
    .Mult_Ctrl_Busy       (busy),
    .Mult_Ctrl_Done       (done)
  );

  assign outs = {load_ops, clear_p, load_p, shift, carry, busy, done};

  // Behavioural datapath: operand regs, product reg with async clear, adder
  always_ff @(posedge clk) begin
    if (load_ops) begin
      areg <= a_in;
      mreg <= b_in;
    end else if (shift) begin
      mreg <= {1'b0, mreg[3:1]};
    end
  end

  always_ff @(posedge clk or posedge clear_p) begin
    if (clear_p)     p <= 8'd0;
    else if (load_p) p[7:4] <= sum[3:0];
    else if (shift)  p <= {carry, p[7:1]};
  end

  assign sum        = {1'b0, p[7:4]} + {1'b0, areg};
  assign adder_cout = force_cout ? 1'b1 : sum[4];
  assign q0         = load_ops ? b_in[0] : (shift ? mreg[1] : mreg[0]);

  a_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot(dut.state));
  a_ld_sh:   assert property (@(posedge clk) disable iff (rst) !(load_p && shift));
  a_clr_p:   assert property (@(posedge clk) disable iff (rst) clear_p |-> (dut.state == S_INIT));
  a_done_w:  assert property (@(posedge clk) disable iff (rst) done |=> !done);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_mult(input string tag, input logic [3:0] av, input logic [3:0] bv,
                          input logic fc, input logic [63:0] exp_trace, input int exp_lat,
                          input int exp_adds, input int exp_carries, input int exp_prod);
    logic [63:0] trace;
    int lat, adds, shifts, carries, ctx_err, prev, code;
    bit seen;
    trace = '0; lat = 0; adds = 0; shifts = 0; carries = 0; ctx_err = 0; prev = 0; seen = 0;
    a_in = av; b_in = bv; force_cout = fc; start = 1'b1;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      code = load_ops ? 1 : load_p ? 2 : shift ? 3 : done ? 4 : 0;
      trace = {trace[59:0], 4'(code)};
      if (load_p) adds++;
      if (shift)  shifts++;
      if (carry) begin
        carries++;
        if (prev != 2 || !shift) ctx_err++;
      end
      if (clear_p != load_ops) ctx_err++;
      if (busy != (code == 1 || code == 2 || code == 3)) ctx_err++;
      prev = code;
      if (done) begin
        seen = 1;
        lat  = n;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"},   64'(lat), 64'(exp_lat));
    check({tag, "_trace"},     trace, exp_trace);
    check({tag, "_adds"},      64'(adds), 64'(exp_adds));
    check({tag, "_shifts"},    64'(shifts), 64'd4);
    check({tag, "_carries"},   64'(carries), 64'(exp_carries));
    check({tag, "_ctx"},       64'(ctx_err), 64'd0);
    check({tag, "_product"},   64'(p), 64'(exp_prod));
    force_cout = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int dones, d1, d2, init_after, idle_outs;
    bit seen_add;

    // Reset state
    #12;
    check("in_reset_outs", 64'(outs), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_outs", 64'(outs), 64'd0);

    // Reset asserted in the middle of an ADD cycle
    a_in = 4'd13; b_in = 4'b1011; start = 1'b1;
    seen_add = 0;
    for (int n = 0; n < 6 && !seen_add; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (load_p) seen_add = 1;
    end
    check("midadd_reached", 64'(seen_add), 64'd1);
    rst = 1'b1;
    #1;
    check("midadd_reset_outs", 64'(outs), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("after_abort_dones", 64'(dones), 64'd0);
    check("after_abort_idle", 64'(outs), 64'd0);

    // tag, a, b, force_cout, trace, latency, adds, carries, product
    run_mult("m13x11",  4'd13, 4'd11, 1'b0, 64'h123233234,  9, 3, 2, 143);
    run_mult("m15x15",  4'd15, 4'd15, 1'b0, 64'h1232323234, 10, 4, 3, 225);
    run_mult("m15x15f", 4'd15, 4'd15, 1'b1, 64'h1232323234, 10, 4, 4, 241);
    run_mult("m7x0",    4'd7,  4'd0,  1'b0, 64'h133334,      6, 0, 0, 0);

    // Start held high: back-to-back runs with one IDLE cycle in between
    a_in = 4'd7; b_in = 4'd0; start = 1'b1;
    d1 = -1; d2 = -1; init_after = -1; idle_outs = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (d1 >= 0 && n == d1 + 1) idle_outs = int'(outs);
      if (d1 >= 0 && init_after < 0 && load_ops) init_after = n;
      if (done) begin
        if (d1 < 0)      d1 = n;
        else if (d2 < 0) d2 = n;
      end
    end
    start = 1'b0;
    check("held_idle_outs", 64'(idle_outs), 64'd0);
    check("held_done_to_init", 64'(init_after - d1), 64'd2);
    check("held_done_period", 64'(d2 - d1), 64'd7);
    repeat (12) @(posedge clk);
    #1;

    // Start pulsed while busy is ignored
    a_in = 4'd13; b_in = 4'b1011; start = 1'b1;
    dones = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      start = (n == 4);
      if (done) dones++;
    end
    start = 1'b0;
    check("busy_pulse_dones", 64'(dones), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
